ring_fifo: RTL and testbench

- Synchronous show-ahead FIFO: the buffering DUT whose push/pop/data traffic a magic-packet scoreboard monitors.
- Accepts data on push and presents the oldest entry on data_out.
- Exposes occupancy so monitors can be wired directly to its handshake: push, pop and data_in are shared with the scoreboard, and data_out feeds the scoreboard's comparison input.
- Serves as both a formal verification target and a reusable buffer.

---
 rtl/ring_fifo_dff.sv | 22 ++
 rtl/ring_fifo_wrap_ptr.sv | 27 ++
 rtl/ring_fifo.sv | 83 ++++++++
 tb/tb_ring_fifo.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/ring_fifo_dff.sv
// Enabled register with asynchronous active-high reset to zero.
// Shared storage primitive for counters and other control state.
module dff_en #(
  parameter int W = 1
) (
  input  logic         rst,
  input  logic         clk,
  input  logic         en,
  input  logic [W-1:0] D,
  output logic [W-1:0] Q
);

  logic [W-1:0] r_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)     r_q <= '0;
    else if (en) r_q <= D;
  end

  assign Q = r_q;

endmodule

// File: rtl/ring_fifo_wrap_ptr.sv
// Modulo-DEPTH pointer with async reset. The wrap is an explicit compare
// so DEPTH need not be a power of two.
module wrap_ptr #(
  parameter int DEPTH  = 8,
  parameter int PTRWID = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inc,
  output logic [PTRWID-1:0] ptr
);

  localparam logic [PTRWID-1:0] LAST = PTRWID'(DEPTH - 1);

  logic [PTRWID-1:0] r_ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (inc) begin
      r_ptr <= (r_ptr == LAST) ? '0 : r_ptr + PTRWID'(1);
    end
  end

  assign ptr = r_ptr;

endmodule

// File: rtl/ring_fifo.sv
// Show-ahead ring FIFO: head is driven combinationally onto data_out and
// full/empty are derived from the occupancy counter, never from pointers.
module ring_fifo #(
  parameter int DEPTH  = 8,
  parameter int WIDTH  = 8,
  parameter int CNTWID = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [WIDTH-1:0]  data_in,
  output logic [WIDTH-1:0]  data_out,
  output logic              empty,
  output logic              full,
  output logic [CNTWID-1:0] cnt,
  output logic              push_ok,
  output logic              pop_ok
);

  localparam int PTRWID = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0]  r_mem [DEPTH];
  logic [PTRWID-1:0] w_wr_ptr;
  logic [PTRWID-1:0] w_rd_ptr;
  logic [CNTWID-1:0] w_cnt_q;
  logic [CNTWID-1:0] w_cnt_d;

  assign empty   = (w_cnt_q == '0);
  assign full    = (w_cnt_q == CNTWID'(DEPTH));
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign cnt     = w_cnt_q;

  // Only loaded when exactly one side is accepted, so the direction is push_ok.
  assign w_cnt_d = push_ok ? (w_cnt_q + CNTWID'(1)) : (w_cnt_q - CNTWID'(1));

  dff_en #(.W(CNTWID)) u_cnt (
    .rst (rst),
    .clk (clk),
    .en  (push_ok ^ pop_ok),
    .D   (w_cnt_d),
    .Q   (w_cnt_q)
  );

  wrap_ptr #(.DEPTH(DEPTH), .PTRWID(PTRWID)) u_wr_ptr (
    .clk (clk),
    .rst (rst),
    .inc (push_ok),
    .ptr (w_wr_ptr)
  );

  wrap_ptr #(.DEPTH(DEPTH), .PTRWID(PTRWID)) u_rd_ptr (
    .clk (clk),
    .rst (rst),
    .inc (pop_ok),
    .ptr (w_rd_ptr)
  );

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (push_ok) r_mem[w_wr_ptr] <= data_in;
  end

  assign data_out = r_mem[w_rd_ptr];

`ifdef FORMAL
  logic [PTRWID:0] w_ptr_diff;
  assign w_ptr_diff = ({1'b0, w_wr_ptr} + (PTRWID+1)'(DEPTH) - {1'b0, w_rd_ptr})
                      % (PTRWID+1)'(DEPTH);

  a_cnt_range : assert property (@(posedge clk) disable iff (rst)
    w_cnt_q <= CNTWID'(DEPTH));
  a_ptr_cnt : assert property (@(posedge clk) disable iff (rst)
    (PTRWID+1)'(w_ptr_diff) == (PTRWID+1)'(w_cnt_q % CNTWID'(DEPTH)));
  a_not_both : assert property (@(posedge clk) disable iff (rst)
    !(empty && full));
  a_cnt_step : assert property (@(posedge clk) disable iff (rst)
    (w_cnt_q == $past(w_cnt_q)) || (w_cnt_q == $past(w_cnt_q) + CNTWID'(1)) ||
    (w_cnt_q == $past(w_cnt_q) - CNTWID'(1)));
`endif

endmodule

// File: tb/tb_ring_fifo.sv
// Directed bench for ring_fifo: an 8-deep and a 5-deep instance share one
// clock; inputs change 1ns after each rising edge, checks settle before the next.
module tb_ring_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic       push_a, pop_a, push_b, pop_b;
  logic [7:0] din_a, din_b;
  logic [7:0] dout_a, dout_b;
  logic       empty_a, full_a, pok_a, qok_a;
  logic       empty_b, full_b, pok_b, qok_b;
  logic [3:0] cnt_a, cnt_b;

  int n_vec = 0;
  int n_bad = 0;
  logic [7:0] exp_q[$];
  logic [7:0] e;

  always #5 clk = ~clk;

  ring_fifo #(.DEPTH(8), .WIDTH(8)) dut_a (
    .clk(clk), .rst(rst), .push(push_a), .pop(pop_a), .data_in(din_a),
    .data_out(dout_a), .empty(empty_a), .full(full_a), .cnt(cnt_a),
    .push_ok(pok_a), .pop_ok(qok_a)
  );

  ring_fifo #(.DEPTH(5), .WIDTH(8)) dut_b (
    .clk(clk), .rst(rst), .push(push_b), .pop(pop_b), .data_in(din_b),
    .data_out(dout_b), .empty(empty_b), .full(full_b), .cnt(cnt_b),
    .push_ok(pok_b), .pop_ok(qok_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input logic ps, input logic pp, input logic [7:0] d);
    push_a = ps; pop_a = pp; din_a = d;
    #1;
  endtask

  initial begin
    rst = 1'b1;
    push_a = 0; pop_a = 0; din_a = 0;
    push_b = 0; pop_b = 0; din_b = 0;
    #2;
    chk("rst_empty", empty_a, 1);
    chk("rst_full", full_a, 0);
    chk("rst_cnt", cnt_a, 0);
    rst = 1'b0;
    tick();

    // Pop while empty is ignored
    for (int i = 0; i < 3; i++) begin
      drive_a(0, 1, 8'h00);
      chk("empty_pop_ok", qok_a, 0);
      tick();
      chk("empty_pop_cnt", cnt_a, 0);
    end

    // Three pushes then three pops
    for (int i = 0; i < 3; i++) begin
      drive_a(1, 0, 8'(8'h11 * (i + 1)));
      tick();
      chk("p3_cnt_up", cnt_a, i + 1);
    end
    for (int i = 0; i < 3; i++) begin
      drive_a(0, 1, 8'h00);
      chk("p3_dout", dout_a, 8'h11 * (i + 1));
      chk("p3_pop_ok", qok_a, 1);
      tick();
      chk("p3_cnt_dn", cnt_a, 2 - i);
    end
    chk("p3_empty", empty_a, 1);

    // Fill to full, overflow push rejected, drain
    for (int i = 0; i < 8; i++) begin
      drive_a(1, 0, 8'(i));
      tick();
    end
    chk("fill_full", full_a, 1);
    chk("fill_cnt", cnt_a, 8);
    drive_a(1, 0, 8'hFF);
    chk("ovf_push_ok", pok_a, 0);
    tick();
    chk("ovf_cnt", cnt_a, 8);
    for (int i = 0; i < 8; i++) begin
      drive_a(0, 1, 8'h00);
      chk("drain_dout", dout_a, i);
      tick();
    end
    chk("drain_empty", empty_a, 1);

    // Empty with simultaneous push and pop: no fall-through
    drive_a(1, 1, 8'hA5);
    chk("ep_push_ok", pok_a, 1);
    chk("ep_pop_ok", qok_a, 0);
    tick();
    chk("ep_cnt", cnt_a, 1);
    chk("ep_dout", dout_a, 8'hA5);
    drive_a(0, 1, 8'h00);
    tick();
    chk("ep_clear", empty_a, 1);

    // Full with simultaneous push and pop: no write-through
    exp_q.delete();
    for (int i = 0; i < 8; i++) begin
      drive_a(1, 0, 8'(8'h30 + i));
      exp_q.push_back(8'(8'h30 + i));
      tick();
    end
    drive_a(1, 1, 8'h5A);
    chk("fp_pop_ok", qok_a, 1);
    chk("fp_push_ok", pok_a, 0);
    e = exp_q.pop_front();
    chk("fp_dout", dout_a, e);
    tick();
    chk("fp_cnt", cnt_a, 7);

    // Steady concurrent traffic at cnt=7 across pointer wrap
    for (int i = 0; i < 20; i++) begin
      drive_a(1, 1, 8'(8'h5A + i));
      chk("cc8_both_ok", {pok_a, qok_a}, 2'b11);
      e = exp_q.pop_front();
      exp_q.push_back(8'(8'h5A + i));
      chk("cc8_dout", dout_a, e);
      tick();
      chk("cc8_cnt", cnt_a, 7);
    end
    drive_a(0, 0, 8'h00);

    // Same traffic on the non-power-of-two depth, held at cnt=4
    exp_q.delete();
    for (int i = 0; i < 5; i++) begin
      push_b = 1; pop_b = 0; din_b = 8'(i + 1);
      exp_q.push_back(8'(i + 1));
      tick();
    end
    chk("d5_full", full_b, 1);
    push_b = 1; pop_b = 1; din_b = 8'h5A;
    #1;
    chk("d5_fp_ok", {pok_b, qok_b}, 2'b01);
    e = exp_q.pop_front();
    chk("d5_fp_dout", dout_b, e);
    tick();
    chk("d5_fp_cnt", cnt_b, 4);
    for (int i = 0; i < 20; i++) begin
      push_b = 1; pop_b = 1; din_b = 8'(8'h5A + i);
      #1;
      e = exp_q.pop_front();
      exp_q.push_back(8'(8'h5A + i));
      chk("cc5_dout", dout_b, e);
      tick();
      chk("cc5_cnt", cnt_b, 4);
    end
    push_b = 0; pop_b = 0;

    // Async reset mid-operation; dut_a holds 7 entries already
    tick();
    #2;
    rst = 1'b1;
    #1;
    chk("arst_empty", empty_a, 1);
    chk("arst_cnt", cnt_a, 0);
    chk("arst_b_cnt", cnt_b, 0);
    rst = 1'b0;
    tick();
    drive_a(1, 0, 8'h77);
    tick();
    drive_a(0, 1, 8'h00);
    chk("post_rst_dout", dout_a, 8'h77);
    chk("post_rst_pop_ok", qok_a, 1);
    tick();
    chk("post_rst_empty", empty_a, 1);
    drive_a(0, 0, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
